// File: rtl/inst_fetch.sv
// inst_fetch: MIPS IF stage; owns the PC and issues in-order instruction reads.
// Returned words queue in a small prefetch FIFO ahead of the registered IF/ID outputs.
module inst_fetch #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IF_OUT,
  output logic [31:0] if_pc,
  output logic        if_valid
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULLN = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } stateT;

  stateT state;
  stateT stateNxt;

  logic [31:0]   fetchPc;
  logic [31:0]   respPc;
  logic [31:0]   redirPc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outNxt;
  logic [CW-1:0] liveOut;
  logic [CW-1:0] discardCnt;
  logic [CW-1:0] discardNxt;
  logic [CW-1:0] fifoCount;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [31:0]   fifoData [FIFO_DEPTH];
  logic [31:0]   fifoPc   [FIFO_DEPTH];

  logic rspNow;
  logic accept;
  logic push;
  logic pop;
  logic fifoEmpty;
  logic fifoFull;
  logic unusedRpc;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign redirPc   = {redirect_pc[31:2], 2'b00};
  assign unusedRpc = ^redirect_pc[1:0];

  // A response with nothing outstanding is stale (e.g. across reset)
  assign rspNow    = imem_rvalid & (outstanding != '0);
  assign liveOut   = outstanding - CW'(rspNow);
  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == FULLN);

  assign imem_req  = (state == RUN) & ~redirect &
                     (({1'b0, outstanding} + {1'b0, fifoCount}) < DEPTH);
  assign imem_addr = fetchPc;
  assign accept    = imem_req & imem_ready;

  assign push = rspNow & (state == RUN) & ~redirect;
  assign pop  = ~stall & ~redirect & ~fifoEmpty;

  assign outNxt = outstanding + CW'(accept) - CW'(rspNow);

  always_comb begin
    stateNxt   = state;
    discardNxt = discardCnt;
    unique case (state)
      BOOT: begin
        stateNxt = RUN;
      end
      RUN: begin
        if (redirect && liveOut != '0) begin
          stateNxt   = FLUSH;
          discardNxt = liveOut;
        end
      end
      FLUSH: begin
        if (rspNow && discardCnt != '0) begin
          discardNxt = discardCnt - CW'(1);
        end
        if (discardCnt == '0 && !redirect) begin
          stateNxt = RUN;
        end
      end
      default: begin
        stateNxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetchPc     <= PC_RESET;
      respPc      <= PC_RESET;
      outstanding <= '0;
      discardCnt  <= '0;
    end else begin
      state       <= stateNxt;
      outstanding <= outNxt;
      discardCnt  <= discardNxt;
      if (redirect) begin
        fetchPc <= redirPc;
        respPc  <= redirPc;
      end else begin
        if (accept) begin
          fetchPc <= fetchPc + 32'd4;
        end
        if (push) begin
          respPc <= respPc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else if (redirect) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) begin
        wrPtr <= ptrInc(wrPtr);
      end
      if (pop) begin
        rdPtr <= ptrInc(rdPtr);
      end
      fifoCount <= fifoCount + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoData[wrPtr] <= imem_rdata;
      fifoPc[wrPtr]   <= respPc;
    end
  end

  // Redirect squashes the IF/ID register even while decode is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_OUT   <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (redirect) begin
      IF_OUT   <= '0;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (!fifoEmpty) begin
        IF_OUT   <= fifoData[rdPtr];
        if_pc    <= fifoPc[rdPtr];
        if_valid <= 1'b1;
      end else begin
        IF_OUT   <= '0;
        if_valid <= 1'b0;
      end
    end
  end

  pushFullChk: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !pop && fifoFull)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: random fetch traffic against an in-order memory model;
// a monitor scores each word decode consumes against the expected PC stream.
module tb_inst_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IF_OUT;
  logic [31:0] if_pc;
  logic        if_valid;

  inst_fetch #(
    .PC_RESET  (PC_RESET),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .IF_OUT     (IF_OUT),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } expT;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memT;

  expT expQ[$];
  memT memQ[$];

  int nVec = 0;
  int nErr = 0;
  int nDeliv = 0;
  int lastDeliv = 0;
  int cyc = 0;
  int pStall, pRedir, pReady, maxLat;
  int stallHold = 0;
  int stallRun = 0;
  bit forceRedir = 0;
  bit chkStallDrop = 0;
  logic [31:0] modelPc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkLive(input string nm);
    nVec++;
    if (nDeliv <= lastDeliv) begin
      nErr++;
      $display("FAIL %s: delivered %0d want more than %0d", nm, nDeliv, lastDeliv);
    end
    lastDeliv = nDeliv;
  endtask

  task automatic setMode(input int s, input int r, input int rdy, input int lat);
    pStall = s;
    pRedir = r;
    pReady = rdy;
    maxLat = lat;
  endtask

  task automatic step();
    expT e;
    memT m;
    @(negedge clk);
    #1;
    stall = (stallHold > 0) || ($urandom_range(99) < pStall);
    if (stallHold > 0) stallHold--;
    imem_ready  = ($urandom_range(99) < pReady);
    redirect    = forceRedir || ($urandom_range(99) < pRedir);
    redirect_pc = ($urandom_range(7) == 0 || forceRedir) ?
                  32'h0000_0103 : {16'h0, 16'($urandom)};
    forceRedir = 0;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(memQ[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (stall) stallRun++;
    else stallRun = 0;
    if (chkStallDrop && stallRun >= 4)
      chk("req_drop_on_stall", 32'(imem_req), 32'd0);
    if (redirect) chk("req_low_on_redirect", 32'(imem_req), 32'd0);
    if (imem_req && imem_ready) begin
      chk("imem_addr", imem_addr, modelPc);
      e.pc   = modelPc;
      e.data = memWord(modelPc);
      expQ.push_back(e);
      m.addr = imem_addr;
      m.due  = cyc + int'($urandom_range(maxLat, 1));
      memQ.push_back(m);
      modelPc = modelPc + 32'd4;
    end
    if (redirect) begin
      expQ.delete();
      modelPc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    if (imem_rvalid) void'(memQ.pop_front());
    cyc++;
  endtask

  // First cycle after release is BOOT; a stray response there must be ignored
  task automatic releaseReset();
    @(negedge clk);
    #1;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    cyc++;
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    #1;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    memQ.delete();
    expQ.delete();
    modelPc = PC_RESET;
    stallRun = 0;
    repeat (n) @(posedge clk);
    releaseReset();
  endtask

  initial begin : monitor
    logic        pStallR, pRedirR, pReqPend;
    logic        pValid;
    logic [31:0] pOut, pPc, pAddr;
    bit          havePrev;
    expT         e;
    havePrev = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_IF_OUT", IF_OUT, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, PC_RESET);
        havePrev = 0;
      end else begin
        if (!havePrev) begin
          chk("boot_no_req", 32'(imem_req), 32'd0);
        end else if (pRedirR) begin
          chk("redir_if_valid", 32'(if_valid), 32'd0);
          chk("redir_IF_OUT", IF_OUT, 32'd0);
        end else if (pStallR) begin
          chk("stall_hold_valid", 32'(if_valid), 32'(pValid));
          chk("stall_hold_out", IF_OUT, pOut);
          chk("stall_hold_pc", if_pc, pPc);
        end
        if (havePrev && pReqPend && !redirect) begin
          chk("req_stable", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, pAddr);
        end
        if (!if_valid) chk("nop_when_invalid", IF_OUT, 32'd0);
        if (if_valid && !stall && !redirect) begin
          if (expQ.size() == 0) begin
            nVec++;
            nErr++;
            $display("FAIL deliver: unexpected word pc %h want none", if_pc);
          end else begin
            e = expQ.pop_front();
            chk("if_pc", if_pc, e.pc);
            chk("IF_OUT", IF_OUT, e.data);
            nDeliv++;
          end
        end
        pStallR  = stall;
        pRedirR  = redirect;
        pReqPend = imem_req && !imem_ready;
        pValid   = if_valid;
        pOut     = IF_OUT;
        pPc      = if_pc;
        pAddr    = imem_addr;
        havePrev = 1;
      end
    end
  end

  initial begin
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    modelPc     = PC_RESET;
    setMode(0, 0, 100, 1);
    repeat (3) @(posedge clk);
    releaseReset();

    repeat (40) step();
    chkLive("stream");

    chkStallDrop = 1;
    stallHold = 5;
    repeat (12) step();
    chkStallDrop = 0;
    chkLive("stall_release");

    setMode(20, 10, 100, 3);
    repeat (300) step();
    chkLive("redirect_mix");

    setMode(10, 5, 40, 3);
    repeat (300) step();
    chkLive("ready_mix");

    for (int r = 0; r < 4; r++) begin
      setMode(15, 4, 70, 3);
      repeat (80) step();
      setMode(0, 0, 100, 3);
      forceRedir = 1;
      step();
      doReset(2);
    end

    setMode(10, 5, 80, 2);
    repeat (200) step();
    chkLive("after_resets");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
